// File: rtl/bcd_addsub_responder.sv
// Digit-serial packed-BCD adder/subtractor responder for the operand1/operand2/E interface.
// Optional macro DEC_SUB_EN enables subtraction (sub input, borrow logic and the FIX state).
module bcd_addsub_responder #(
  parameter int unsigned NDIGITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   E,
  input  logic [4*NDIGITS-1:0]   operand1,
  input  logic [4*NDIGITS-1:0]   operand2,
  input  logic                   sub,
  output logic [4*NDIGITS-1:0]   Result,
  output logic [3:0]             Flags,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned W  = 4 * NDIGITS;
  localparam int unsigned CW = $clog2(NDIGITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StAdd,
    StDone
`ifdef DEC_SUB_EN
    , StFix
`endif
  } state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    r_q;
  logic            c_q;
  logic [CW-1:0]   idx_q;
`ifdef DEC_SUB_EN
  logic            sub_q;
`else
  logic            unused_sub;
  assign unused_sub = sub;
`endif

  function automatic logic has_invalid(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  logic [3:0]   dig;
  logic         c_next;
  logic [W-1:0] r_shift;
  logic         last_dig;
  logic [4:0]   sum;
`ifdef DEC_SUB_EN
  logic [4:0]   need;
  logic [3:0]   fix_dig;
  logic         fix_borrow;
  logic [4:0]   fix_need;
  logic [W-1:0] fix_shift;
`endif

  assign last_dig = (idx_q == CW'(NDIGITS - 1));

  always_comb begin
    sum    = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};
    dig    = (sum > 5'd9) ? 4'(sum - 5'd10) : sum[3:0];
    c_next = (sum > 5'd9);
`ifdef DEC_SUB_EN
    need = {1'b0, b_q[3:0]} + {4'b0, c_q};
    if (sub_q) begin
      if ({1'b0, a_q[3:0]} < need) begin
        dig    = 4'({1'b0, a_q[3:0]} + 5'd10 - need);
        c_next = 1'b1;
      end else begin
        dig    = 4'({1'b0, a_q[3:0]} - need);
        c_next = 1'b0;
      end
    end
    // Ten's complement: 0 - raw, borrow rippling up from digit 0.
    fix_need   = {1'b0, r_q[3:0]} + {4'b0, c_q};
    fix_borrow = (fix_need != 5'd0);
    fix_dig    = fix_borrow ? 4'(5'd10 - fix_need) : 4'd0;
    fix_shift  = (r_q >> 4) | (W'(fix_dig) << (W - 4));
`endif
    r_shift = (r_q >> 4) | (W'(dig) << (W - 4));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      Result  <= '0;
      Flags   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
`ifdef DEC_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (E) begin
            a_q     <= operand1;
            b_q     <= operand2;
`ifdef DEC_SUB_EN
            sub_q   <= sub;
`endif
            busy    <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (has_invalid(a_q) || has_invalid(b_q)) begin
            Result  <= '0;
            Flags   <= 4'b1000;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q   <= '0;
            c_q     <= 1'b0;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          r_q   <= r_shift;
          c_q   <= c_next;
          idx_q <= idx_q + 1'b1;
          if (last_dig) begin
`ifdef DEC_SUB_EN
            if (sub_q && c_next) begin
              idx_q   <= '0;
              c_q     <= 1'b0;
              state_q <= StFix;
            end else begin
              Result  <= r_shift;
              // After a borrow-free subtract c_next is 0, so C is 0 there.
              Flags   <= {2'b00, c_next, (r_shift == '0)};
              done    <= 1'b1;
              state_q <= StDone;
            end
`else
            Result  <= r_shift;
            Flags   <= {2'b00, c_next, (r_shift == '0)};
            done    <= 1'b1;
            state_q <= StDone;
`endif
          end
        end
`ifdef DEC_SUB_EN
        StFix: begin
          r_q   <= fix_shift;
          c_q   <= fix_borrow;
          idx_q <= idx_q + 1'b1;
          if (last_dig) begin
            Result  <= fix_shift;
            Flags   <= 4'b0100;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
`endif
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_responder.sv
// Directed scoreboard bench for bcd_addsub_responder; sub tests compile only with DEC_SUB_EN.
module tb_bcd_addsub_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        E;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        sub;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic        busy;
  logic        done;

  bcd_addsub_responder #(.NDIGITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .E        (E),
    .operand1 (operand1),
    .operand2 (operand2),
    .sub      (sub),
    .Result   (Result),
    .Flags    (Flags),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, Result, e.res);
      chk({tag, "_flags"}, {28'd0, Flags}, {28'd0, e.flg});
    end
  endtask

  // Latency counts edges inclusively: the capture edge is 1, the edge raising done is lat.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] er, input logic [3:0] ef,
                        input int lat);
    int edges;
    logic [31:0] hold;
    sb.push_back('{res: er, flg: ef});
    @(negedge clk);
    operand1 = a;
    operand2 = b;
    sub      = s;
    E        = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    E        = 1'b0;
    operand1 = 32'h0000_0000;
    operand2 = 32'h0000_0000;
    sub      = 1'b0;
    while (done !== 1'b1 && edges < 64) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, edges, lat);
    check_done(tag);
    hold = Result;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_hold"}, Result, hold);
  endtask

  initial begin
    int edges;
    int ndone;
    int first_at;
    int second_at;
    rst      = 1'b1;
    E        = 1'b0;
    operand1 = '0;
    operand2 = '0;
    sub      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", Result, 32'd0);
    chk("reset_flags", {28'd0, Flags}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    run_op("add_basic", 32'h0000_0045, 32'h0000_0057, 1'b0, 32'h0000_0102, 4'b0000, 10);
    run_op("add_ovf", 32'h9999_9999, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b0011, 10);
    run_op("add_full", 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 4'b0000, 10);
    run_op("add_ovf2", 32'h5000_0000, 32'h5000_0003, 1'b0, 32'h0000_0003, 4'b0010, 10);
    run_op("inval_a", 32'h0000_000A, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1000, 2);
    run_op("inval_b", 32'h0000_0001, 32'hF000_0000, 1'b0, 32'h0000_0000, 4'b1000, 2);
`ifdef DEC_SUB_EN
    run_op("sub_neg", 32'h0000_0012, 32'h0000_0034, 1'b1, 32'h0000_0022, 4'b0100, 18);
    run_op("sub_zero", 32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_0000, 4'b0001, 10);
    run_op("sub_pos", 32'h0000_5000, 32'h0000_0001, 1'b1, 32'h0000_4999, 4'b0000, 10);
    run_op("sub_neg1", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'h0000_0001, 4'b0100, 18);
`else
    run_op("sub_ignored", 32'h0000_0012, 32'h0000_0034, 1'b1, 32'h0000_0046, 4'b0000, 10);
`endif

    // Reset in the middle of ADD: outputs clear and no done follows.
    @(negedge clk);
    operand1 = 32'h0000_0011;
    operand2 = 32'h0000_0022;
    E        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    E = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", Result, 32'd0);
    chk("midrst_flags", {28'd0, Flags}, 32'd0);
    rst   = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // Back-to-back with E held high; operands change while busy.
    sb.push_back('{res: 32'h3333_3333, flg: 4'b0000});
    sb.push_back('{res: 32'h0000_0009, flg: 4'b0000});
    @(negedge clk);
    operand1 = 32'h1111_1111;
    operand2 = 32'h2222_2222;
    sub      = 1'b0;
    E        = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    operand1  = 32'h0000_0005;
    operand2  = 32'h0000_0004;
    ndone     = 0;
    first_at  = 0;
    second_at = 0;
    while (ndone < 2 && edges < 64) begin
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first_at = edges;
          check_done("b2b_first");
        end else begin
          second_at = edges;
          check_done("b2b_second");
        end
      end else if (ndone == 1 && busy === 1'b1 && E === 1'b1) begin
        E = 1'b0;
        chk("b2b_hold_during_busy", Result, 32'h3333_3333);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("b2b_first_latency", first_at, 10);
    chk("b2b_second_latency", second_at, 21);
    E = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_addsub_responder.md
Name: bcd_addsub_responder

Overview:
- DUT-side responder for the operand1/operand2/E command interface driven by the stimulus BFM.
- Accepts two packed-BCD operands when E is high, computes the sum (or difference) digit-serially, then presents Result and Flags with a one-cycle done pulse.
- Result and Flags hold stable until the next completion, so the monitor can sample them at any time after done.

Parameters:
- NDIGITS, 8, number of packed BCD digits per operand. Operand and result width is 4*NDIGITS (32 at default).

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- E  in  1  operation request, level-sensitive. Sampled only in IDLE.
- operand1  in  4*NDIGITS  packed BCD operand A; digit 0 is bits [3:0].
- operand2  in  4*NDIGITS  packed BCD operand B.
- sub  in  1  1 = A-B, 0 = A+B. Captured with the operands; only honoured under DEC_SUB_EN.
- Result  out  4*NDIGITS  packed BCD result, registered.
- Flags  out  4  [0] Z zero, [1] C carry-out/overflow, [2] N negative, [3] I invalid digit. Registered.
- busy  out  1  high from the capture edge until the return to IDLE.
- done  out  1  one-cycle pulse; Result and Flags are valid from this cycle onward.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; Result=0, Flags=0, busy=0, done=0.
  - Internal registers are cleared. Reset aborts any operation in flight; no done is produced for it.
- States: IDLE, CHECK, ADD, FIX, DONE.
- IDLE:
  - E=1 at an edge (T0): capture operand1, operand2, sub; set busy=1; go to CHECK.
  - E=0: stay in IDLE.
- CHECK (edge T1):
  - If any captured nibble of either operand is >9: go to DONE, load Result=0, Flags=4'b1000.
  - Otherwise: digit index=0, carry/borrow=0, go to ADD.
- ADD, one digit per edge (T2..T(NDIGITS+1)):
  - Add: s=a+b+c. If s>9 then digit=s-10, c=1; else digit=s, c=0.
  - Sub: d=a-b-borrow. If d<0 then digit=d+10, borrow=1; else digit=d, borrow=0.
  - After the last digit:
    - Add: load Result; C=final carry; Z=(Result==0); N=0; I=0; go to DONE.
    - Sub, final borrow=0: load Result; Z as above; C=0, N=0; go to DONE.
    - Sub, final borrow=1: go to FIX.
- FIX, NDIGITS edges:
  - Replace the raw result with its ten's complement, computed digit-serially as 0-raw with borrow rippling from digit 0.
  - Then load Result=|A-B|, N=1, Z=0, C=0; go to DONE.
- DONE (one cycle):
  - done=1; next edge goes to IDLE with busy=0 and done=0.
  - If E is still high in the following IDLE cycle, a new capture occurs. Back-to-back ops are legal; the BFM holds E high.
- Latency from the capture edge T0 to Result/Flags update and done high:
  - Invalid operand: 2 edges.
  - Add, or sub without borrow: NDIGITS+2 edges (10 at default).
  - Sub with borrow: 2*NDIGITS+2 edges (18 at default).
- Operand changes while busy=1 are ignored; the captured copies are used.
- Overflow: the add result wraps modulo 10^NDIGITS with C=1. Z is computed on the wrapped value.
- Result and Flags change only on the edge entering DONE, or on reset.

Optional Feature:
- DEC_SUB_EN
  - Defined: the sub input is honoured and the FIX state exists.
  - Not defined: sub is ignored and treated as 0; the FIX state and borrow logic are not compiled; N is always 0.

Test Plan:
- Reset behaviour: assert rst mid-ADD -> next cycle busy=0, done=0, Result=0, Flags=0; no done pulse follows.
- Basic add: A=00000045, B=00000057, sub=0 -> Result=00000102, Flags=4'b0000, done exactly 10 edges after capture.
- Add overflow: A=99999999, B=00000001 -> Result=00000000, Flags=4'b0011 (C=1, Z=1).
- Invalid digit: A=0000000A, B=00000001 -> Result=00000000, Flags=4'b1000, done 2 edges after capture.
- Subtraction (DEC_SUB_EN):
  - A=00000012, B=00000034, sub=1 -> Result=00000022, Flags=4'b0100, latency 18.
  - A=00001234, B=00001234, sub=1 -> Result=0, Flags=4'b0001, latency 10.
- Back-to-back with E held high: change operands during busy -> the first result uses the captured values; the second op captures the new values in the cycle after done.
